cassette_save: RTL and testbench
================================

Name: cassette_save

Overview:
- Tape-save counterpart of the TAP loader: serialises a memory region into the TAP byte stream the loader consumes.
- Output is an 8-bit valid/ready byte stream toward the ioctl upload path (HPS file save).
- Header, code and trailer are emitted in the exact order the loader's state machine expects.
- Code bytes are fetched from machine RAM through a 1-cycle-latency read port.

Parameters:
- PREAMBLE_A5, default 0: number of 0xA5 filler bytes emitted between the closing quote and the file-type byte (the loader ignores them).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only when busy=0
- file_type  in  8  0x42 'B', 0x4D 'M', 0x44 'D'
- start_addr  in  16  first RAM address to save
- byte_count  in  16  number of code bytes, must be >=1
- exec_addr  in  16  execution address (emitted for 'M' only)
- mem_addr  out  16  RAM read address
- mem_rd  out  1  read strobe; mem_din is valid the cycle after
- mem_din  in  8  RAM read data
- out_data  out  8  stream byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts the byte
- busy  out  1  high from the start-accept cycle until the done cycle
- done  out  1  one-cycle pulse when the last byte transfers
- error  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values: every output 0; state IDLE. Reset mid-operation aborts at once: out_valid drops, no done pulse.
- Transfer occurs on out_valid && out_ready. While out_valid=1 and out_ready=0, out_data is held stable and out_valid stays high. At most one byte is offered per state.
- Start handling:
  - start with busy=0 latches all inputs and sets busy=1.
  - start while busy=1 is ignored.
  - Unsupported file_type or byte_count=0: error pulses for 1 cycle, nothing is emitted, busy stays 0.
- Length field L = byte_count-1, 16-bit. The loader's count is inclusive, so L+1 code bytes follow.
- Emission order:
  - 'B': 0x22, 0x22, A5×PREAMBLE_A5, 0x42, L[7:0], L[15:8], code×byte_count. No trailer.
  - 'D': 0x22, 0x22, A5×N, 0x44, L lo, L hi, code×byte_count, TRAIL.
  - 'M': 0x22, 0x22, A5×N, 0x4D, L lo, L hi, start_addr lo, start_addr hi, code×byte_count, TRAIL, exec_addr lo, exec_addr hi.
- States: IDLE, QUOTE1, QUOTE2, PREAMBLE, TYPE, LENLO, LENHI, LOADLO, LOADHI, FETCH, MEMWAIT, CODE, TRAIL, EXECLO, EXECHI, DONE.
  - Each emit state advances on transfer.
  - PREAMBLE is skipped when N=0.
  - LENHI goes to LOADLO for 'M' and to FETCH otherwise.
- Code fetch:
  - FETCH drives mem_addr=ptr, mem_rd=1 for exactly 1 cycle.
  - MEMWAIT loads out_data<=mem_din and asserts out_valid.
  - CODE waits for transfer, then increments ptr (wraps 0xFFFF->0x0000), decrements the remaining count, and returns to FETCH unless the count reaches 0.
  - Latency: at least 3 cycles per code byte. mem_rd is never asserted outside FETCH.
- Exit from the code phase: 'B' goes to DONE; 'D' goes TRAIL->DONE; 'M' goes TRAIL->EXECLO->EXECHI->DONE.
- DONE: done=1 and busy=0 in the same cycle; next state IDLE. A start in the done cycle is ignored.
- A start with out_ready held low stalls indefinitely; there is no timeout.

Optional Feature:
- Macro CASSETTE_SAVE_CHECKSUM_EN.
- Defined: the TRAIL byte is the 8-bit modulo-256 sum of all emitted code bytes. It is accumulated at each code transfer and cleared on start accept.
- Undefined: the TRAIL byte is 0x00 and no accumulator is synthesised.
- The 'B' stream is unaffected either way.

Test Plan:
- 'B', start_addr=0x694D, byte_count=3, RAM {0x11,0x22,0x33}, out_ready=1 -> stream 22 22 42 02 00 11 22 33; done pulses once; mem_rd pulses 3 times at 0x694D..0x694F.
- 'M', start_addr=0xC000, byte_count=2, exec_addr=0xC001, RAM {0x3E,0xC9}, checksum on -> 22 22 4D 01 00 00 C0 3E C9 07 01 C0 (0x07 = (0x3E+0xC9) mod 256); with macro off, TRAIL=00.
- 'D', start_addr=0xFFFF, byte_count=2, PREAMBLE_A5=2 -> 22 22 A5 A5 44 01 00 followed by the bytes at 0xFFFF then 0x0000, then TRAIL.
- Backpressure: out_ready toggled pseudo-randomly -> out_data never changes while valid&&!ready; byte sequence identical to the out_ready=1 run.
- file_type=0x58 or byte_count=0 -> error pulse, out_valid stays 0, busy stays 0. start while busy -> no effect on the in-progress stream.
- reset asserted mid-CODE -> next cycle all outputs 0; a following start produces a complete fresh stream beginning 22 22.

Source files
------------

// File: rtl/cassette_save.sv
// cassette_save: serialises a RAM region into the TAP byte stream the tape loader consumes.
// Define CASSETTE_SAVE_CHECKSUM_EN to make the TRAIL byte the modulo-256 sum of the code bytes (otherwise 0x00).
module cassette_save #(
    parameter int PREAMBLE_A5 = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  file_type,
    input  logic [15:0] start_addr,
    input  logic [15:0] byte_count,
    input  logic [15:0] exec_addr,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_din,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_QUOTE1   = 4'd1;
    localparam logic [3:0] S_QUOTE2   = 4'd2;
    localparam logic [3:0] S_PREAMBLE = 4'd3;
    localparam logic [3:0] S_TYPE     = 4'd4;
    localparam logic [3:0] S_LENLO    = 4'd5;
    localparam logic [3:0] S_LENHI    = 4'd6;
    localparam logic [3:0] S_LOADLO   = 4'd7;
    localparam logic [3:0] S_LOADHI   = 4'd8;
    localparam logic [3:0] S_FETCH    = 4'd9;
    localparam logic [3:0] S_MEMWAIT  = 4'd10;
    localparam logic [3:0] S_CODE     = 4'd11;
    localparam logic [3:0] S_TRAIL    = 4'd12;
    localparam logic [3:0] S_EXECLO   = 4'd13;
    localparam logic [3:0] S_EXECHI   = 4'd14;
    localparam logic [3:0] S_DONE     = 4'd15;

    localparam logic [7:0] T_BASIC = 8'h42;
    localparam logic [7:0] T_MCODE = 8'h4D;
    localparam logic [7:0] T_DATA  = 8'h44;

    localparam logic [15:0] PRE_LAST = (PREAMBLE_A5 > 0) ? 16'(PREAMBLE_A5 - 1) : 16'd0;

    // Stream handshake: a byte moves on the cycle out_valid && out_ready are both high;
    // while stalled, out_valid stays high and out_data is held because both are decoded from stable state.
    logic [3:0]  state;
    logic [7:0]  type_q;
    logic [15:0] len_q;
    logic [15:0] exec_q;
    logic [15:0] ptr;
    logic [15:0] rem;
    logic [7:0]  data_q;
    logic [15:0] pre_cnt;
    logic [7:0]  trail_byte;
    logic        type_ok;
    logic        start_ok;
    logic        xfer;

    assign type_ok  = (file_type == T_BASIC) || (file_type == T_MCODE) || (file_type == T_DATA);
    assign start_ok = type_ok && (byte_count != 16'd0);
    assign xfer     = out_valid && out_ready;

    assign mem_rd   = (state == S_FETCH);
    assign mem_addr = mem_rd ? ptr : 16'h0000;
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);

`ifdef CASSETTE_SAVE_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else if (state == S_IDLE && start && start_ok) begin
            sum_q <= 8'h00;
        end else if (state == S_CODE && xfer) begin
            sum_q <= sum_q + data_q;
        end
    end

    assign trail_byte = sum_q;
`else
    assign trail_byte = 8'h00;
`endif

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        case (state)
            S_QUOTE1, S_QUOTE2: begin out_valid = 1'b1; out_data = 8'h22;         end
            S_PREAMBLE:         begin out_valid = 1'b1; out_data = 8'hA5;         end
            S_TYPE:             begin out_valid = 1'b1; out_data = type_q;        end
            S_LENLO:            begin out_valid = 1'b1; out_data = len_q[7:0];    end
            S_LENHI:            begin out_valid = 1'b1; out_data = len_q[15:8];   end
            S_LOADLO:           begin out_valid = 1'b1; out_data = ptr[7:0];      end
            S_LOADHI:           begin out_valid = 1'b1; out_data = ptr[15:8];     end
            S_CODE:             begin out_valid = 1'b1; out_data = data_q;        end
            S_TRAIL:            begin out_valid = 1'b1; out_data = trail_byte;    end
            S_EXECLO:           begin out_valid = 1'b1; out_data = exec_q[7:0];   end
            S_EXECHI:           begin out_valid = 1'b1; out_data = exec_q[15:8];  end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            type_q  <= 8'h00;
            len_q   <= 16'h0000;
            exec_q  <= 16'h0000;
            ptr     <= 16'h0000;
            rem     <= 16'h0000;
            data_q  <= 8'h00;
            pre_cnt <= 16'h0000;
            error   <= 1'b0;
        end else begin
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            type_q  <= file_type;
                            len_q   <= byte_count - 16'd1;
                            exec_q  <= exec_addr;
                            ptr     <= start_addr;
                            rem     <= byte_count;
                            pre_cnt <= 16'h0000;
                            state   <= S_QUOTE1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_QUOTE1: if (xfer) state <= S_QUOTE2;
                S_QUOTE2: if (xfer) state <= (PREAMBLE_A5 > 0) ? S_PREAMBLE : S_TYPE;
                S_PREAMBLE: begin
                    if (xfer) begin
                        pre_cnt <= pre_cnt + 16'd1;
                        if (pre_cnt == PRE_LAST) state <= S_TYPE;
                    end
                end
                S_TYPE:   if (xfer) state <= S_LENLO;
                S_LENLO:  if (xfer) state <= S_LENHI;
                S_LENHI:  if (xfer) state <= (type_q == T_MCODE) ? S_LOADLO : S_FETCH;
                S_LOADLO: if (xfer) state <= S_LOADHI;
                S_LOADHI: if (xfer) state <= S_FETCH;
                S_FETCH:  state <= S_MEMWAIT;
                S_MEMWAIT: begin
                    data_q <= mem_din;
                    state  <= S_CODE;
                end
                S_CODE: begin
                    if (xfer) begin
                        ptr <= ptr + 16'd1;
                        rem <= rem - 16'd1;
                        if (rem == 16'd1) state <= (type_q == T_BASIC) ? S_DONE : S_TRAIL;
                        else              state <= S_FETCH;
                    end
                end
                S_TRAIL:  if (xfer) state <= (type_q == T_MCODE) ? S_EXECLO : S_DONE;
                S_EXECLO: if (xfer) state <= S_EXECHI;
                S_EXECHI: if (xfer) state <= S_DONE;
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cassette_save.sv
// Directed bench for cassette_save: one DUT with no preamble, one with two A5 filler bytes.
module tb_cassette_save;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start_p;
    logic [7:0]  file_type;
    logic [15:0] start_addr, byte_count, exec_addr;
    logic [15:0] mem_addr, mem_addr_p;
    logic        mem_rd, mem_rd_p;
    logic [7:0]  mem_din, mem_din_p;
    logic [7:0]  out_data, out_data_p;
    logic        out_valid, out_valid_p;
    logic        out_ready, out_ready_p;
    logic        busy, busy_p, done, done_p, error, error_p;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  ram [0:65535];
    logic [7:0]  got_q[$], got_p_q[$], exp_q[$];
    logic [15:0] rd_q[$], rd_p_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

`ifdef CASSETTE_SAVE_CHECKSUM_EN
    localparam logic [7:0] TR_M = 8'h07;
    localparam logic [7:0] TR_D = 8'h01;
`else
    localparam logic [7:0] TR_M = 8'h00;
    localparam logic [7:0] TR_D = 8'h00;
`endif

    always #5 clk = ~clk;

    cassette_save #(.PREAMBLE_A5(0)) dut (
        .clk(clk), .reset(reset), .start(start), .file_type(file_type),
        .start_addr(start_addr), .byte_count(byte_count), .exec_addr(exec_addr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_din(mem_din),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .error(error)
    );

    cassette_save #(.PREAMBLE_A5(2)) dut_p (
        .clk(clk), .reset(reset), .start(start_p), .file_type(file_type),
        .start_addr(start_addr), .byte_count(byte_count), .exec_addr(exec_addr),
        .mem_addr(mem_addr_p), .mem_rd(mem_rd_p), .mem_din(mem_din_p),
        .out_data(out_data_p), .out_valid(out_valid_p), .out_ready(out_ready_p),
        .busy(busy_p), .done(done_p), .error(error_p)
    );

    // RAM model with one cycle of read latency
    always @(posedge clk) begin
        if (mem_rd)   mem_din   <= ram[mem_addr];
        if (mem_rd_p) mem_din_p <= ram[mem_addr_p];
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                total++;
                if (!out_valid || out_data !== prev_data) begin
                    bad++;
                    $display("FAIL hold: valid=%b data=%02h required valid=1 data=%02h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready)     got_q.push_back(out_data);
            if (out_valid_p && out_ready_p) got_p_q.push_back(out_data_p);
            if (mem_rd)   rd_q.push_back(mem_addr);
            if (mem_rd_p) rd_p_q.push_back(mem_addr_p);
            if (done)  done_cnt++;
            if (error) err_cnt++;
        end
        prev_stall = out_valid && !out_ready && !reset;
        prev_data  = out_data;
    end

    task automatic do_start(input logic [7:0] ft, input logic [15:0] sa, input logic [15:0] bc,
                            input logic [15:0] ea, input bit to_p);
        @(posedge clk); #1;
        file_type = ft; start_addr = sa; byte_count = bc; exec_addr = ea;
        if (to_p) start_p = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_p = 1'b0;
    endtask

    task automatic wait_done(input bit use_p, input bit toggle, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (use_p ? done_p : done) begin
                ok = 1'b1;
                break;
            end
            if (toggle) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL timeout: done not seen within 400 cycles, required done=1");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_p = 1'b0; out_ready = 1'b1; out_ready_p = 1'b1;
        file_type = 8'h00; start_addr = 16'h0; byte_count = 16'h0; exec_addr = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({out_valid, out_data, busy, done, error, mem_rd, mem_addr} !== 30'h0) begin
            bad++;
            $display("FAIL reset_outs: v=%b d=%02h busy=%b done=%b err=%b rd=%b a=%04h required all 0",
                     out_valid, out_data, busy, done, error, mem_rd, mem_addr);
        end
        total++;
        if ({out_valid_p, busy_p, done_p, error_p, mem_rd_p} !== 5'h0) begin
            bad++;
            $display("FAIL reset_outs_p: v=%b busy=%b done=%b err=%b rd=%b required all 0",
                     out_valid_p, busy_p, done_p, error_p, mem_rd_p);
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_basic_b();
        bit ok;
        int d0;
        ram[16'h694D] = 8'h11; ram[16'h694E] = 8'h22; ram[16'h694F] = 8'h33;
        got_q.delete(); rd_q.delete(); d0 = done_cnt; out_ready = 1'b1;
        do_start(8'h42, 16'h694D, 16'd3, 16'h0000, 1'b0);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b_busy: busy=%b required 1", busy); end
        wait_done(1'b0, 1'b0, ok);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b_busy_done: busy=%b required 0", busy); end
        exp_q = '{8'h22, 8'h22, 8'h42, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL b_len: got %0d bytes required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i > 0) total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL b_byte%0d: got %02h required %02h", i, got_q[i], exp_q[i]);
                end
            end
        end
        @(negedge clk); #1;
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL b_done_cnt: got %0d required 1", done_cnt - d0); end
        total++;
        if (rd_q.size() != 3) begin
            bad++; $display("FAIL b_rd_cnt: got %0d required 3", rd_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (rd_q[i] !== 16'h694D + 16'(i)) begin
                    bad++; $display("FAIL b_rd_addr%0d: got %04h required %04h", i, rd_q[i], 16'h694D + 16'(i));
                end
            end
        end
    endtask

    task automatic test_m(input bit toggle);
        bit ok;
        ram[16'hC000] = 8'h3E; ram[16'hC001] = 8'hC9;
        got_q.delete(); out_ready = 1'b1;
        do_start(8'h4D, 16'hC000, 16'd2, 16'hC001, 1'b0);
        wait_done(1'b0, toggle, ok);
        out_ready = 1'b1;
        exp_q = '{8'h22, 8'h22, 8'h4D, 8'h01, 8'h00, 8'h00, 8'hC0, 8'h3E, 8'hC9, TR_M, 8'h01, 8'hC0};
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL m_len(bp=%0d): got %0d bytes required %0d", toggle, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i > 0) total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL m_byte%0d(bp=%0d): got %02h required %02h", i, toggle, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_d_wrap();
        bit ok;
        ram[16'hFFFF] = 8'h5A; ram[16'h0000] = 8'hA7;
        got_p_q.delete(); rd_p_q.delete();
        do_start(8'h44, 16'hFFFF, 16'd2, 16'h0000, 1'b1);
        wait_done(1'b1, 1'b0, ok);
        exp_q = '{8'h22, 8'h22, 8'hA5, 8'hA5, 8'h44, 8'h01, 8'h00, 8'h5A, 8'hA7, TR_D};
        total++;
        if (got_p_q.size() != exp_q.size()) begin
            bad++; $display("FAIL d_len: got %0d bytes required %0d", got_p_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i > 0) total++;
                if (got_p_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL d_byte%0d: got %02h required %02h", i, got_p_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (rd_p_q.size() != 2 || rd_p_q[0] !== 16'hFFFF || rd_p_q[1] !== 16'h0000) begin
            bad++; $display("FAIL d_rd_wrap: got %0d reads first=%04h required 2 reads FFFF,0000",
                            rd_p_q.size(), (rd_p_q.size() > 0) ? rd_p_q[0] : 16'hXXXX);
        end
    endtask

    task automatic test_error();
        int e0;
        e0 = err_cnt; got_q.delete();
        do_start(8'h58, 16'h1000, 16'd1, 16'h0000, 1'b0);
        @(negedge clk);
        total++;
        if ({error, busy, out_valid} !== 3'b100) begin
            bad++; $display("FAIL err_type: err=%b busy=%b valid=%b required 1,0,0", error, busy, out_valid);
        end
        @(negedge clk);
        total++;
        if ({error, busy, out_valid} !== 3'b000) begin
            bad++; $display("FAIL err_pulse: err=%b busy=%b valid=%b required 0,0,0", error, busy, out_valid);
        end
        do_start(8'h42, 16'h1000, 16'd0, 16'h0000, 1'b0);
        @(negedge clk);
        total++;
        if ({error, busy, out_valid} !== 3'b100) begin
            bad++; $display("FAIL err_zero: err=%b busy=%b valid=%b required 1,0,0", error, busy, out_valid);
        end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (err_cnt - e0 != 2 || got_q.size() != 0) begin
            bad++; $display("FAIL err_count: pulses=%0d bytes=%0d required 2 pulses 0 bytes", err_cnt - e0, got_q.size());
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        got_q.delete(); rd_q.delete(); out_ready = 1'b1;
        do_start(8'h42, 16'h694D, 16'd3, 16'h0000, 1'b0);
        repeat (4) @(posedge clk);
        do_start(8'h4D, 16'hC000, 16'd2, 16'hC001, 1'b0);
        wait_done(1'b0, 1'b0, ok);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, out_valid, error} !== 3'b000) begin
            bad++; $display("FAIL done_start: busy=%b valid=%b err=%b required 0,0,0", busy, out_valid, error);
        end
        exp_q = '{8'h22, 8'h22, 8'h42, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        total++;
        if (got_q != exp_q) begin
            bad++; $display("FAIL busy_start_stream: got %0d bytes required B stream of %0d", got_q.size(), exp_q.size());
        end
        total++;
        if (rd_q.size() != 3) begin bad++; $display("FAIL busy_start_rd: got %0d reads required 3", rd_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        int d0;
        got_q.delete(); out_ready = 1'b1; seen = 1'b0;
        do_start(8'h42, 16'h694D, 16'd3, 16'h0000, 1'b0);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (mem_rd) begin seen = 1'b1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL mid_fetch: mem_rd=0 required 1 within 50 cycles"); end
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            bad++; $display("FAIL mid_code: valid=%b data=%02h required 1,11", out_valid, out_data);
        end
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, out_data, busy, done, error, mem_rd, mem_addr} !== 30'h0) begin
            bad++; $display("FAIL mid_reset: v=%b d=%02h busy=%b done=%b err=%b rd=%b a=%04h required all 0",
                            out_valid, out_data, busy, done, error, mem_rd, mem_addr);
        end
        @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (done_cnt != d0) begin bad++; $display("FAIL mid_no_done: done pulses=%0d required 0", done_cnt - d0); end
        got_q.delete();
        do_start(8'h42, 16'h694D, 16'd3, 16'h0000, 1'b0);
        wait_done(1'b0, 1'b0, ok);
        exp_q = '{8'h22, 8'h22, 8'h42, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        total++;
        if (got_q != exp_q) begin
            bad++; $display("FAIL mid_fresh: got %0d bytes first=%02h required full B stream starting 22",
                            got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hXX);
        end
    endtask

    initial begin
        test_reset();
        test_basic_b();
        test_m(1'b0);
        test_m(1'b1);
        test_d_wrap();
        test_error();
        test_start_while_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
